// File: rtl/wb_ram_slave.sv
// -----------------------------------------------------------------------------
// wb_ram_slave
// Wishbone B4 slave with an embedded word-addressed RAM. It supports classic or
// pipelined handshaking, a programmable number of wait states before each
// response, and an error response for addresses outside its window.
//
// Parameters
//   DATA_W       data width in bits (multiple of 8, power of 2)
//   SIZE         RAM depth in words (>= 2)
//   BASE_ADDR    byte base address of the window (aligned to DATA_W/8)
//   WAIT_STATES  extra cycles before ack/err (0..15)
//   PIPELINED    0 = classic handshake, 1 = B4 pipelined (stall used)
//
// Ports
//   clk_i       clock
//   rstn_i      asynchronous active-low reset
//   wb_cyc_i    bus cycle active
//   wb_stb_i    request strobe
//   wb_we_i     1 = write, 0 = read
//   wb_adr_i    byte address
//   wb_sel_i    byte lane enables
//   wb_dat_i    write data
//   wb_dat_o    read data, non-zero only during a read ack
//   wb_ack_o    one-cycle transfer acknowledge
//   wb_err_o    one-cycle error acknowledge (out-of-window access)
//   wb_stall_o  pipelined mode: request not accepted this cycle
// -----------------------------------------------------------------------------
module wb_ram_slave #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SIZE        = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          PIPELINED   = 1'b0
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_stall_o
);

  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned LSB = $clog2(NB);
  localparam int unsigned AW  = $clog2(SIZE);
  localparam logic [3:0]  WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                we_q, we_d;
  logic [NB-1:0]       sel_q, sel_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                oor_q, oor_d;

  logic [DATA_W-1:0]   mem [SIZE];

  // Address decode: byte offset into the window, then word index.
  logic [31:0]         off;
  logic [31:0]         idx_full;
  logic                oor;
  logic                accept;

  assign off      = wb_adr_i - BASE_ADDR;
  assign idx_full = off >> LSB;
  assign oor      = (wb_adr_i < BASE_ADDR) || (idx_full >= 32'(SIZE));

  // In pipelined mode a request may also be taken during RESP: the previous
  // transfer completes in that same cycle, so at most one stays outstanding
  // and a deasserted stall always means "accepted".
  always_comb begin
    accept = 1'b0;
    if (wb_cyc_i && wb_stb_i && !wb_stall_o) begin
      if (state_q == S_IDLE)
        accept = 1'b1;
      else if (PIPELINED && (state_q == S_RESP))
        accept = 1'b1;
    end
  end

  // State and request registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      oor_q   <= oor_d;
    end
  end

  // Next-state logic and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    oor_d   = oor_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WS_LAST) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (accept) begin
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      idx_d  = idx_full[AW-1:0];
      we_d   = wb_we_i;
      sel_d  = wb_sel_i;
      wdat_d = wb_dat_i;
      oor_d  = oor;
    end
  end

  // Outputs. Dropping cyc during RESP suppresses the response and the write.
  always_comb begin
    wb_stall_o = PIPELINED && (state_q == S_WAIT);
    wb_ack_o   = (state_q == S_RESP) && wb_cyc_i && !oor_q;
    wb_err_o   = (state_q == S_RESP) && wb_cyc_i && oor_q;
    wb_dat_o   = '0;
    if (wb_ack_o && !we_q)
      wb_dat_o = mem[idx_q];
  end

  // RAM write, committed on the edge that ends the acked RESP cycle.
  always_ff @(posedge clk_i) begin
    if (wb_ack_o && we_q) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (sel_q[b])
          mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
module tb_wb_ram_slave;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rstn;
  always #5 clk = ~clk;

  logic        cyc  [NI];
  logic        stb  [NI];
  logic        we   [NI];
  logic [31:0] adr  [NI];
  logic [3:0]  sel  [NI];
  logic [31:0] wdat [NI];
  logic [31:0] rdat [NI];
  logic        ack  [NI];
  logic        err  [NI];
  logic        stall[NI];

  // 0: defaults (classic, no wait, base 0)
  // 1: pipelined, no wait
  // 2: pipelined, 3 wait states
  // 3: classic, 2 wait states, base 0x100
  int lat_exp  [NI] = '{1, 1, 4, 3};
  int stall_exp[NI] = '{0, 0, 3, 0};
  bit pipe     [NI] = '{1'b0, 1'b1, 1'b1, 1'b0};

  wb_ram_slave u_a (
    .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_stall_o(stall[0]));

  wb_ram_slave #(.PIPELINED(1'b1)) u_b (
    .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_stall_o(stall[1]));

  wb_ram_slave #(.PIPELINED(1'b1), .WAIT_STATES(3)) u_c (
    .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
    .wb_adr_i(adr[2]), .wb_sel_i(sel[2]), .wb_dat_i(wdat[2]), .wb_dat_o(rdat[2]),
    .wb_ack_o(ack[2]), .wb_err_o(err[2]), .wb_stall_o(stall[2]));

  wb_ram_slave #(.WAIT_STATES(2), .BASE_ADDR(32'h0000_0100), .SIZE(32)) u_d (
    .clk_i(clk), .rstn_i(rstn), .wb_cyc_i(cyc[3]), .wb_stb_i(stb[3]), .wb_we_i(we[3]),
    .wb_adr_i(adr[3]), .wb_sel_i(sel[3]), .wb_dat_i(wdat[3]), .wb_dat_o(rdat[3]),
    .wb_ack_o(ack[3]), .wb_err_o(err[3]), .wb_stall_o(stall[3]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  // One master transfer. Inputs change 1 time unit after a rising edge,
  // outputs are sampled on the falling edge. n counts rising edges from the
  // request being presented to the response being visible.
  task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output bit g_ack, output bit g_err,
                      output logic [31:0] rd, output int n, output int stalls);
    bit done;
    done = 1'b0; n = 0; stalls = 0; g_ack = 1'b0; g_err = 1'b0; rd = '0;
    @(posedge clk); #1;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; wdat[k] = d;
    while (!done && n < 40) begin
      @(negedge clk);
      if (stall[k]) stalls++;
      if (ack[k] || err[k]) begin
        done = 1'b1; g_ack = ack[k]; g_err = err[k]; rd = rdat[k];
      end
      @(posedge clk); #1;
      if (done) begin
        cyc[k] = 1'b0; stb[k] = 1'b0;
      end else begin
        n++;
        if (pipe[k]) stb[k] = 1'b0;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
  endtask

  task automatic run(input int k, input string nm, input bit w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d, input bit exp_err,
                     input logic [31:0] exp_rd);
    bit ga, ge; logic [31:0] rd; int n, st;
    xfer(k, w, a, s, d, ga, ge, rd, n, st);
    chk({nm, ".resp"}, 64'({ga, ge}), exp_err ? 64'd1 : 64'd2);
    chk({nm, ".lat"}, 64'(n), 64'(lat_exp[k]));
    chk({nm, ".stall"}, 64'(st), 64'(stall_exp[k]));
    if (exp_err)
      chk({nm, ".errdat"}, 64'(rd), 64'd0);
    else if (!w)
      chk({nm, ".rdat"}, 64'(rd), 64'(exp_rd));
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    int          c;
    bit          e;
    bit          r;
    logic [31:0] d;
  } exp_t;

  vec_t        tbl[$];
  exp_t        q[$];
  logic [31:0] ma[32];
  logic [31:0] mb[32];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < NI; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      adr[k] = '0; sel[k] = '0; wdat[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset.outs", 64'({ack[k], err[k], stall[k]}), 64'd0);
      chk("reset.dat", 64'(rdat[k]), 64'd0);
    end
    rstn = 1'b1;

    // ---------------- table-driven vectors, instance A ----------------
    tbl.push_back('{1'b1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0004, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF});
    tbl.push_back('{1'b1, 32'h0000_0004, 4'h1, 32'h0000_00AA, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0004, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEAA});
    tbl.push_back('{1'b1, 32'h0000_0007, 4'h8, 32'h1122_3344, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0005, 4'hF, 32'h0,         1'b0, 32'h11AD_BEAA});
    tbl.push_back('{1'b1, 32'h0000_0000, 4'hF, 32'h0102_0304, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h0000_007C, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h0000_0080, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0080, 4'hF, 32'h0,         1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 32'h0102_0304});
    tbl.push_back('{1'b0, 32'h0000_007C, 4'hF, 32'h0,         1'b0, 32'hCAFE_F00D});
    tbl.push_back('{1'b1, 32'h0000_0004, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0004, 4'hF, 32'h0,         1'b0, 32'h11AD_BEAA});
    tbl.push_back('{1'b1, 32'h0000_0004, 4'h6, 32'h5566_7788, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h0000_0004, 4'hF, 32'h0,         1'b0, 32'h1166_77AA});
    tbl.push_back('{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         1'b1, 32'h0});
    for (int i = 0; i < tbl.size(); i++)
      run(0, $sformatf("a.vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].wd,
          tbl[i].err, tbl[i].rd);

    // ---------------- random single transfers, instance A ----------------
    for (int i = 0; i < 32; i++) begin
      ma[i] = $urandom;
      run(0, "a.fill", 1'b1, 32'(i * 4), 4'hF, ma[i], 1'b0, 32'h0);
    end
    for (int i = 0; i < 40; i++) begin
      int unsigned ix;
      bit          w;
      logic [3:0]  s;
      logic [31:0] d;
      logic [31:0] a;
      ix = $urandom_range(35);
      w  = 1'($urandom_range(1));
      s  = 4'($urandom_range(15));
      d  = $urandom;
      a  = 32'(ix * 4 + $urandom_range(3));
      if (ix >= 32)
        run(0, "a.rnd.oor", w, a, s, d, 1'b1, 32'h0);
      else if (w) begin
        ma[ix] = merge(ma[ix], d, s);
        run(0, "a.rnd.wr", 1'b1, a, s, d, 1'b0, 32'h0);
      end else
        run(0, "a.rnd.rd", 1'b0, a, s, d, 1'b0, ma[ix]);
    end

    // ---------------- instance C: wait states, stall, async reset ----------------
    run(2, "c.wr0", 1'b1, 32'h0, 4'hF, 32'h0F0F_0F0F, 1'b0, 32'h0);
    run(2, "c.rd0", 1'b0, 32'h0, 4'hF, 32'h0,         1'b0, 32'h0F0F_0F0F);
    run(2, "c.wr8", 1'b1, 32'h8, 4'hF, 32'h1111_2222, 1'b0, 32'h0);
    @(posedge clk); #1;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h8; sel[2] = 4'hF;
    wdat[2] = 32'h9999_9999;
    @(posedge clk); #1;
    stb[2] = 1'b0;
    chk("c.stall_wait", 64'(stall[2]), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("c.rst_outs", 64'({ack[2], err[2], stall[2]}), 64'd0);
    cyc[2] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run(2, "c.rst_rd", 1'b0, 32'h8, 4'hF, 32'h0, 1'b0, 32'h1111_2222);

    // ---------------- instance B: pipelined back-to-back ----------------
    for (int i = 0; i < 32; i++) begin
      mb[i] = $urandom;
      run(1, "b.fill", 1'b1, 32'(i * 4), 4'hF, mb[i], 1'b0, 32'h0);
    end
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) adr[1] = 32'(i * 4);
      else       stb[1] = 1'b0;
      @(negedge clk);
      chk("b.b2b.stall", 64'(stall[1]), 64'd0);
      if (i == 0)
        chk("b.b2b.first", 64'({ack[1], err[1]}), 64'd0);
      else begin
        chk("b.b2b.ack", 64'({ack[1], err[1]}), 64'd2);
        chk("b.b2b.rdat", 64'(rdat[1]), 64'(mb[i-1]));
      end
      @(posedge clk); #1;
    end
    cyc[1] = 1'b0;

    // ---------------- instance B: random pipelined stream vs model ----------------
    @(posedge clk); #1;
    cyc[1] = 1'b1;
    for (int c = 0; c <= 200; c++) begin
      exp_t        e;
      int unsigned ix;
      stb[1] = 1'b0;
      if (c < 200 && $urandom_range(3) != 0) begin
        ix      = $urandom_range(39);
        stb[1]  = 1'b1;
        we[1]   = 1'($urandom_range(1));
        sel[1]  = 4'($urandom_range(15));
        wdat[1] = $urandom;
        adr[1]  = 32'(ix * 4 + $urandom_range(3));
        e.c = c; e.e = (ix >= 32); e.r = !we[1]; e.d = '0;
        if (!e.e) begin
          if (we[1]) mb[ix] = merge(mb[ix], wdat[1], sel[1]);
          else       e.d = mb[ix];
        end
        q.push_back(e);
      end
      @(negedge clk);
      chk("b.s.stall", 64'(stall[1]), 64'd0);
      if (q.size() != 0 && q[0].c == c - 1) begin
        e = q.pop_front();
        chk("b.s.resp", 64'({ack[1], err[1]}), e.e ? 64'd1 : 64'd2);
        if (e.r && !e.e)
          chk("b.s.rdat", 64'(rdat[1]), 64'(e.d));
      end else
        chk("b.s.idle", 64'({ack[1], err[1]}), 64'd0);
      @(posedge clk); #1;
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;

    // ---------------- instance D: window, err latency, abort ----------------
    run(3, "d.wr100", 1'b1, 32'h100, 4'hF, 32'h5555_AAAA, 1'b0, 32'h0);
    run(3, "d.wr80",  1'b1, 32'h080, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
    run(3, "d.wr180", 1'b1, 32'h180, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
    run(3, "d.rd100", 1'b0, 32'h100, 4'hF, 32'h0,         1'b0, 32'h5555_AAAA);
    run(3, "d.wr17c", 1'b1, 32'h17C, 4'hF, 32'h7777_1234, 1'b0, 32'h0);
    run(3, "d.rd17c", 1'b0, 32'h17C, 4'hF, 32'h0,         1'b0, 32'h7777_1234);
    run(3, "d.old",   1'b1, 32'h108, 4'hF, 32'hAAAA_0000, 1'b0, 32'h0);
    @(posedge clk); #1;
    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; adr[3] = 32'h108; sel[3] = 4'hF;
    wdat[3] = 32'h1234_5678;
    @(posedge clk); #1;
    cyc[3] = 1'b0; stb[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("d.abort", 64'({ack[3], err[3]}), 64'd0);
    end
    run(3, "d.after", 1'b0, 32'h108, 4'hF, 32'h0, 1'b0, 32'hAAAA_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
